mc_control: RTL and testbench

Multi-cycle successor to the single-cycle MIPS32 main decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives per-state datapath controls. Memory accesses use a ready handshake with wait states and a parametrised timeout. It sits between the instruction register (op/func) and the shared multi-cycle datapath (PC, IR, register file, ALU, unified memory port).

---
 rtl/mc_ctrl_pkg.sv | 56 +++++
 rtl/mc_control_if.sv | 39 +++
 rtl/mc_op_decode.sv | 53 +++++
 rtl/mc_control.sv | 178 +++++++++++++++++
 tb/tb_mc_control.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS32 controller: opcodes, funcs,
// FSM states and the datapath mux select values.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;
    localparam logic [1:0] ALU_OR   = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;
    localparam logic [1:0] M2R_LUI = 2'd3;

endpackage

// File: rtl/mc_control_if.sv
// Control bundle between the instruction register / memory port and the
// multi-cycle controller; master is the controller, slave the datapath side.
interface mc_control_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       sign_ext;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;
    logic       timeout;
    logic [2:0] state_o;

    modport master (
        input  op, func, mem_ready,
        output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
               branch_ne, pc_src, alu_src_a, alu_src_b, alu_op, sign_ext,
               reg_write, reg_dst, mem_to_reg, illegal, timeout, state_o
    );

    modport slave (
        output op, func, mem_ready,
        input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
               branch_ne, pc_src, alu_src_a, alu_src_b, alu_op, sign_ext,
               reg_write, reg_dst, mem_to_reg, illegal, timeout, state_o
    );
endinterface

// File: rtl/mc_op_decode.sv
// Combinational instruction classifier: turns op/func into one-hot class
// flags, with anything outside the supported subset reported as illegal.
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic       is_r,
    output logic       is_jr,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_bne,
    output logic       is_j,
    output logic       is_jal,
    output logic       is_ori,
    output logic       is_lui,
    output logic       is_illegal
);

    always_comb begin
        is_r       = 1'b0;
        is_jr      = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        is_ori     = 1'b0;
        is_lui     = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_R: begin
                case (func)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: is_r = 1'b1;
                    F_JR:                             is_jr = 1'b1;
                    default:                          is_illegal = 1'b1;
                endcase
            end
            OP_J:    is_j   = 1'b1;
            OP_JAL:  is_jal = 1'b1;
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_ORI:  is_ori = 1'b1;
            OP_LUI:  is_lui = 1'b1;
            OP_LW:   is_lw  = 1'b1;
            OP_SW:   is_sw  = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS32 main controller: FETCH/DECODE/EXEC/MEM/WB sequencing
// with a ready-handshake memory port and an optional wait-state timeout.
module mc_control
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_control_if.master  bus
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             wait_limit;

    logic is_r, is_jr, is_lw, is_sw, is_beq, is_bne;
    logic is_j, is_jal, is_ori, is_lui, is_illegal;

    mc_op_decode u_dec (
        .op         (bus.op),
        .func       (bus.func),
        .is_r       (is_r),
        .is_jr      (is_jr),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_beq     (is_beq),
        .is_bne     (is_bne),
        .is_j       (is_j),
        .is_jal     (is_jal),
        .is_ori     (is_ori),
        .is_lui     (is_lui),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign wait_limit = TIMEOUT_EN && (cnt_q == CNT_LIMIT);

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        illegal_d         = illegal_q;
        timeout_d         = timeout_q;
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pc_src        = PC_ALU;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_RT;
        bus.alu_op        = ALU_ADD;
        bus.sign_ext      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = DST_RT;
        bus.mem_to_reg    = M2R_ALU;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end else if (wait_limit) begin
                    timeout_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                // ALUOut captures the branch target here for beq/bne in EXEC
                bus.alu_src_b = SRCB_IMM_SH;
                bus.sign_ext  = 1'b1;
                if (is_j || is_jal) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_JUMP;
                    if (is_jal) begin
                        bus.reg_write  = 1'b1;
                        bus.reg_dst    = DST_RA;
                        bus.mem_to_reg = M2R_PC;
                    end
                    state_d = S_FETCH;
                end else if (is_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_r) begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_FUNC;
                    state_d       = S_WB;
                end else if (is_jr) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_RS;
                end else if (is_beq || is_bne) begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = ALU_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_src        = PC_ALUOUT;
                    bus.branch_ne     = is_bne;
                end else if (is_lw || is_sw) begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.sign_ext  = 1'b1;
                    state_d       = S_MEM;
                end else if (is_ori) begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.alu_op    = ALU_OR;
                    state_d       = S_WB;
                end else if (is_lui) begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = M2R_LUI;
                end
            end
            S_MEM: begin
                bus.mem_req = 1'b1;
                bus.i_or_d  = 1'b1;
                bus.mem_we  = is_sw;
                if (bus.mem_ready) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end else if (wait_limit) begin
                    timeout_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = is_r ? DST_RD : DST_RT;
                bus.mem_to_reg = is_lw ? M2R_MDR : M2R_ALU;
                state_d        = S_FETCH;
            end
            default: state_d = S_ERR;
        endcase

        // Every entry into FETCH or MEM starts a fresh wait count
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign bus.illegal = illegal_q;
    assign bus.timeout = timeout_q;
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus pushes the hand-computed control
// vector expected for each cycle, a negedge monitor pops and compares it.
module tb_mc_control;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       sign_ext;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       illegal;
        logic       timeout;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    exp_t  exp_q[$];
    string name_q[$];
    int    compared = 0;
    int    mismatched = 0;

    mc_control_if bus ();

    mc_control #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t e_state(input logic [2:0] st);
        exp_t e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t e_fetch(input logic rdy);
        exp_t e = e_state(3'd1);
        e.mem_req   = 1'b1;
        e.alu_src_b = 2'd1;
        e.ir_write  = rdy;
        e.pc_write  = rdy;
        return e;
    endfunction

    function automatic exp_t e_decode();
        exp_t e = e_state(3'd2);
        e.alu_src_b = 2'd3;
        e.sign_ext  = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_exec_addr();
        exp_t e = e_state(3'd3);
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'd2;
        e.sign_ext  = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_mem(input logic we);
        exp_t e = e_state(3'd4);
        e.mem_req = 1'b1;
        e.i_or_d  = 1'b1;
        e.mem_we  = we;
        return e;
    endfunction

    function automatic exp_t e_wb(input logic [1:0] dst, input logic [1:0] m2r);
        exp_t e = e_state(3'd5);
        e.reg_write  = 1'b1;
        e.reg_dst    = dst;
        e.mem_to_reg = m2r;
        return e;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [5:0] op,
                                 input logic [5:0] fn, input logic rdy,
                                 input exp_t e, input string name);
        @(posedge clk);
        #1;
        rst_n         = rst;
        bus.op        = op;
        bus.func      = fn;
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        exp_t act;
        act = {bus.state_o, bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write,
               bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.pc_src,
               bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.sign_ext,
               bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal,
               bus.timeout};
        compared++;
        if (act !== e) begin
            mismatched++;
            $display("[TB] FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                     name, act.st, act, e.st, e);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front(), name_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        bus.op = 6'h00; bus.func = 6'h00; bus.mem_ready = 1'b0;

        applyStimulus(1'b0, 6'h23, 6'h00, 1'b1, e_state(3'd0), "reset_idle");
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b1, e_state(3'd0), "reset_release");

        // lw, zero wait: 1,2,3,4,5
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b1, e_fetch(1'b1), "lw_fetch");
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b1, e_decode(), "lw_decode");
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b1, e_exec_addr(), "lw_exec");
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b1, e_mem(1'b0), "lw_mem");
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b1, e_wb(2'd0, 2'd1), "lw_wb");

        // add with three FETCH wait states; ready on the limit cycle must win
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0, e_fetch(1'b0), "add_fetch_w0");
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0, e_fetch(1'b0), "add_fetch_w1");
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0, e_fetch(1'b0), "add_fetch_w2");
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b1, e_fetch(1'b1), "add_fetch_rdy");
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b1, e_decode(), "add_decode");
        e = e_state(3'd3); e.alu_src_a = 1'b1; e.alu_op = 2'b10;
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b1, e, "add_exec");
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b1, e_wb(2'd1, 2'd0), "add_wb");

        // beq then bne
        applyStimulus(1'b1, 6'h04, 6'h00, 1'b1, e_fetch(1'b1), "beq_fetch");
        applyStimulus(1'b1, 6'h04, 6'h00, 1'b1, e_decode(), "beq_decode");
        e = e_state(3'd3); e.alu_src_a = 1'b1; e.alu_op = 2'b01;
        e.pc_write_cond = 1'b1; e.pc_src = 2'd1;
        applyStimulus(1'b1, 6'h04, 6'h00, 1'b1, e, "beq_exec");
        applyStimulus(1'b1, 6'h05, 6'h00, 1'b1, e_fetch(1'b1), "bne_fetch");
        applyStimulus(1'b1, 6'h05, 6'h00, 1'b1, e_decode(), "bne_decode");
        e.branch_ne = 1'b1;
        applyStimulus(1'b1, 6'h05, 6'h00, 1'b1, e, "bne_exec");

        // j, jal, jr
        applyStimulus(1'b1, 6'h02, 6'h00, 1'b1, e_fetch(1'b1), "j_fetch");
        e = e_decode(); e.pc_write = 1'b1; e.pc_src = 2'd2;
        applyStimulus(1'b1, 6'h02, 6'h00, 1'b1, e, "j_decode");
        applyStimulus(1'b1, 6'h03, 6'h00, 1'b1, e_fetch(1'b1), "jal_fetch");
        e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
        applyStimulus(1'b1, 6'h03, 6'h00, 1'b1, e, "jal_decode");
        applyStimulus(1'b1, 6'h00, 6'h08, 1'b1, e_fetch(1'b1), "jr_fetch");
        applyStimulus(1'b1, 6'h00, 6'h08, 1'b1, e_decode(), "jr_decode");
        e = e_state(3'd3); e.pc_write = 1'b1; e.pc_src = 2'd3;
        applyStimulus(1'b1, 6'h00, 6'h08, 1'b1, e, "jr_exec");

        // ori, lui
        applyStimulus(1'b1, 6'h0D, 6'h00, 1'b1, e_fetch(1'b1), "ori_fetch");
        applyStimulus(1'b1, 6'h0D, 6'h00, 1'b1, e_decode(), "ori_decode");
        e = e_state(3'd3); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 2'b11;
        applyStimulus(1'b1, 6'h0D, 6'h00, 1'b1, e, "ori_exec");
        applyStimulus(1'b1, 6'h0D, 6'h00, 1'b1, e_wb(2'd0, 2'd0), "ori_wb");
        applyStimulus(1'b1, 6'h0F, 6'h00, 1'b1, e_fetch(1'b1), "lui_fetch");
        applyStimulus(1'b1, 6'h0F, 6'h00, 1'b1, e_decode(), "lui_decode");
        e = e_state(3'd3); e.reg_write = 1'b1; e.mem_to_reg = 2'd3;
        applyStimulus(1'b1, 6'h0F, 6'h00, 1'b1, e, "lui_exec");

        // sw with ready arriving in the 4th MEM cycle: no timeout
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b1, e_fetch(1'b1), "sw_fetch");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b1, e_decode(), "sw_decode");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, e_exec_addr(), "sw_exec");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, e_mem(1'b1), "sw_mem_w0");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, e_mem(1'b1), "sw_mem_w1");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, e_mem(1'b1), "sw_mem_w2");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b1, e_mem(1'b1), "sw_mem_rdy");

        // reset asserted mid-access of lw
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b1, e_fetch(1'b1), "lwrst_fetch");
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b1, e_decode(), "lwrst_decode");
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, e_exec_addr(), "lwrst_exec");
        applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, e_mem(1'b0), "lwrst_mem");
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b1, e_state(3'd0), "lwrst_idle");

        // unsupported opcode: sticky illegal, ERR until reset
        applyStimulus(1'b1, 6'h3F, 6'h00, 1'b1, e_fetch(1'b1), "ill_fetch");
        applyStimulus(1'b1, 6'h3F, 6'h00, 1'b1, e_decode(), "ill_decode");
        e = e_state(3'd6); e.illegal = 1'b1;
        applyStimulus(1'b1, 6'h3F, 6'h00, 1'b1, e, "ill_err");
        applyStimulus(1'b0, 6'h3F, 6'h00, 1'b1, e, "ill_err_hold");
        applyStimulus(1'b1, 6'h00, 6'h21, 1'b1, e_state(3'd0), "ill_reset_idle");

        // unsupported func with op=0
        applyStimulus(1'b1, 6'h00, 6'h21, 1'b1, e_fetch(1'b1), "illf_fetch");
        applyStimulus(1'b1, 6'h00, 6'h21, 1'b1, e_decode(), "illf_decode");
        e = e_state(3'd6); e.illegal = 1'b1;
        applyStimulus(1'b0, 6'h2B, 6'h00, 1'b1, e, "illf_err");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b1, e_state(3'd0), "illf_reset_idle");

        // sw that never completes: timeout after 4 MEM cycles
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b1, e_fetch(1'b1), "to_fetch");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, e_decode(), "to_decode");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, e_exec_addr(), "to_exec");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, e_mem(1'b1), "to_mem_w0");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, e_mem(1'b1), "to_mem_w1");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, e_mem(1'b1), "to_mem_w2");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, e_mem(1'b1), "to_mem_w3");
        e = e_state(3'd6); e.timeout = 1'b1;
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b1, e, "to_err");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b1, e, "to_err_hold");

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
